// File: rtl/pma_window_lookup.sv
// pma_window_lookup: read-side search engine for the phase memory anchor RAM.
// A captured window_id is compared against the tag (word[ID_W+PAYLOAD_W-1:PAYLOAD_W]) of
// every slot, lowest address first, through the RAM's synchronous read port. The engine
// returns the lowest valid matching slot and its payload, or a miss after a full scan.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     lookup request handshake; req_window_id is the id to search for
//   slot_valid          per-slot valid bitmap owned by the anchor writer
//   ram_read_addr       registered RAM read address
//   ram_read_data       RAM read data, valid READ_LATENCY edges after the address is sampled
//   rsp_valid/ready     response handshake; rsp_hit, rsp_addr, rsp_payload held while stalled
//   busy                high while scanning or holding a response
module pma_window_lookup #(
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned ADDR_W       = $clog2(DEPTH),
   parameter int unsigned ID_W         = 12,
   parameter int unsigned PAYLOAD_W    = 132,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ID_W-1:0]           req_window_id,
   input  logic [DEPTH-1:0]          slot_valid,
   output logic [ADDR_W-1:0]         ram_read_addr,
   input  logic [ID_W+PAYLOAD_W-1:0] ram_read_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_hit,
   output logic [ADDR_W-1:0]         rsp_addr,
   output logic [PAYLOAD_W-1:0]      rsp_payload,
   output logic                      busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StScan = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   logic [1:0]           state_q, state_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ADDR_W-1:0]    raddr_q, raddr_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_hit_q, rsp_hit_d;
   logic [ADDR_W-1:0]    rsp_addr_q, rsp_addr_d;
   logic [PAYLOAD_W-1:0] rsp_payload_q, rsp_payload_d;

   // Issue-tag pipeline: stage 0 tracks the address currently on ram_read_addr; stage
   // READ_LATENCY is the read whose data is on ram_read_data this cycle.
   logic [READ_LATENCY:0] pipe_v_q, pipe_v_d;
   logic [ADDR_W-1:0]     pipe_a_q [READ_LATENCY+1];
   logic [ADDR_W-1:0]     pipe_a_d [READ_LATENCY+1];

   logic              cmp_valid;
   logic [ADDR_W-1:0] cmp_addr;
   logic              tag_match;
   logic              cmp_hit;
   logic              cmp_last;

   always_comb begin
      cmp_valid = pipe_v_q[READ_LATENCY];
      cmp_addr  = pipe_a_q[READ_LATENCY];
      tag_match = (ram_read_data[ID_W+PAYLOAD_W-1:PAYLOAD_W] == id_q);
      cmp_hit   = cmp_valid && tag_match && slot_valid[cmp_addr];
      cmp_last  = cmp_valid && (cmp_addr == LastAddr);
   end

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      raddr_d       = raddr_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_hit_d     = rsp_hit_q;
      rsp_addr_d    = rsp_addr_q;
      rsp_payload_d = rsp_payload_q;
      pipe_v_d      = pipe_v_q;
      pipe_a_d      = pipe_a_q;

      case (state_q)
         StIdle: begin
            if (req_valid) begin
               id_d        = req_window_id;
               raddr_d     = '0;
               pipe_v_d    = '0;
               pipe_v_d[0] = 1'b1;
               pipe_a_d[0] = '0;
               state_d     = StScan;
            end
         end

         StScan: begin
            for (int i = 1; i <= int'(READ_LATENCY); i++) begin
               pipe_v_d[i] = pipe_v_q[i-1];
               pipe_a_d[i] = pipe_a_q[i-1];
            end
            // The address saturates at the last slot; no further reads are tagged.
            if (raddr_q != LastAddr) begin
               raddr_d     = raddr_q + 1'b1;
               pipe_v_d[0] = 1'b1;
               pipe_a_d[0] = raddr_q + 1'b1;
            end else begin
               pipe_v_d[0] = 1'b0;
            end

            if (cmp_hit) begin
               rsp_valid_d   = 1'b1;
               rsp_hit_d     = 1'b1;
               rsp_addr_d    = cmp_addr;
               rsp_payload_d = ram_read_data[PAYLOAD_W-1:0];
               pipe_v_d      = '0;   // drop reads still in flight
               state_d       = StResp;
            end else if (cmp_last) begin
               rsp_valid_d   = 1'b1;
               rsp_hit_d     = 1'b0;
               rsp_addr_d    = '0;
               rsp_payload_d = '0;
               pipe_v_d      = '0;
               state_d       = StResp;
            end
         end

         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end

         default: begin
            state_d  = StIdle;
            pipe_v_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         id_q          <= '0;
         raddr_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_hit_q     <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_payload_q <= '0;
         pipe_v_q      <= '0;
         pipe_a_q      <= '{default: '0};
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         raddr_q       <= raddr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_hit_q     <= rsp_hit_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_payload_q <= rsp_payload_d;
         pipe_v_q      <= pipe_v_d;
         pipe_a_q      <= pipe_a_d;
      end
   end

   assign req_ready     = (state_q == StIdle);
   assign busy          = (state_q != StIdle);
   assign ram_read_addr = raddr_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_hit       = rsp_hit_q;
   assign rsp_addr      = rsp_addr_q;
   assign rsp_payload   = rsp_payload_q;

endmodule

// File: tb/tb_pma_window_lookup.sv
// Directed bench for pma_window_lookup with a behavioural one-cycle synchronous-read RAM.
module tb_pma_window_lookup;

   localparam int unsigned DEPTH     = 64;
   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned ID_W      = 12;
   localparam int unsigned PAYLOAD_W = 132;
   localparam int unsigned W         = ID_W + PAYLOAD_W;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [ID_W-1:0]      req_window_id = '0;
   logic [DEPTH-1:0]     slot_valid = '0;
   logic [ADDR_W-1:0]    ram_read_addr;
   logic [W-1:0]         ram_read_data;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic                 rsp_hit;
   logic [ADDR_W-1:0]    rsp_addr;
   logic [PAYLOAD_W-1:0] rsp_payload;
   logic                 busy;

   logic [W-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ram_read_data <= mem[ram_read_addr];

   pma_window_lookup #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .READ_LATENCY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_window_id(req_window_id), .slot_valid(slot_valid), .ram_read_addr(ram_read_addr),
      .ram_read_data(ram_read_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_payload(rsp_payload), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues a request and returns how many edges after acceptance rsp_valid appeared.
   task automatic lookup(input logic [ID_W-1:0] id, output int lat);
      @(negedge clk);
      req_window_id = id;
      req_valid     = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!rsp_valid && lat < 200);
   endtask

   task automatic expect_rsp(input string tag, input logic hit, input int addr,
                             input logic [PAYLOAD_W-1:0] pay, input int lat_exp, input int lat);
      check_eq({tag, "_lat"},     W'(lat),         W'(lat_exp));
      check_eq({tag, "_valid"},   W'(rsp_valid),   W'(1));
      check_eq({tag, "_hit"},     W'(rsp_hit),     W'(hit));
      check_eq({tag, "_addr"},    W'(rsp_addr),    W'(addr));
      check_eq({tag, "_payload"}, W'(rsp_payload), W'(pay));
   endtask

   // With rsp_ready high the response is consumed at the next edge.
   task automatic consume(input string tag);
      @(posedge clk);
      #1;
      check_eq({tag, "_done_valid"}, W'(rsp_valid), W'(0));
      check_eq({tag, "_done_ready"}, W'(req_ready), W'(1));
   endtask

   initial begin
      int lat;
      int cnt;
      int bad;

      for (int i = 0; i < int'(DEPTH); i++) mem[i] = {12'h000, PAYLOAD_W'(i + 1)};

      #12;
      check_eq("rst_req_ready", W'(req_ready),     W'(1));
      check_eq("rst_rsp_valid", W'(rsp_valid),     W'(0));
      check_eq("rst_rsp_hit",   W'(rsp_hit),       W'(0));
      check_eq("rst_rsp_addr",  W'(rsp_addr),      W'(0));
      check_eq("rst_payload",   W'(rsp_payload),   W'(0));
      check_eq("rst_raddr",     W'(ram_read_addr), W'(0));
      check_eq("rst_busy",      W'(busy),          W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Single hit at slot 2.
      mem[2] = {12'h042, PAYLOAD_W'(32'hDEADBEEF)};
      slot_valid[2] = 1'b1;
      lookup(12'h042, lat);
      expect_rsp("hit2", 1'b1, 2, PAYLOAD_W'(32'hDEADBEEF), 4, lat);
      consume("hit2");

      // Hit at slot 5 with a different tag also resident.
      mem[5] = {12'hABC, PAYLOAD_W'(32'h12345678)};
      slot_valid[5] = 1'b1;
      lookup(12'hABC, lat);
      expect_rsp("hit5", 1'b1, 5, PAYLOAD_W'(32'h12345678), 7, lat);
      consume("hit5");

      // Duplicate tags: lowest wins, exactly one response.
      mem[3] = {12'h111, PAYLOAD_W'(32'h0333)};
      mem[9] = {12'h111, PAYLOAD_W'(32'h0999)};
      slot_valid[3] = 1'b1;
      slot_valid[9] = 1'b1;
      lookup(12'h111, lat);
      expect_rsp("dup3", 1'b1, 3, PAYLOAD_W'(32'h0333), 5, lat);
      consume("dup3");
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 if (rsp_valid) cnt++;
      end
      check_eq("dup_once", W'(cnt), W'(0));

      // Invalidated slot 3 is skipped.
      slot_valid[3] = 1'b0;
      lookup(12'h111, lat);
      expect_rsp("dup9", 1'b1, 9, PAYLOAD_W'(32'h0999), 11, lat);
      consume("dup9");

      // Full-scan miss.
      lookup(12'h7FF, lat);
      expect_rsp("miss", 1'b0, 0, '0, 65, lat);
      check_eq("miss_raddr", W'(ram_read_addr), W'(63));
      consume("miss");
      check_eq("miss_raddr_hold", W'(ram_read_addr), W'(63));

      // Response stall with an ignored request pulse.
      rsp_ready = 1'b0;
      lookup(12'h042, lat);
      expect_rsp("stall", 1'b1, 2, PAYLOAD_W'(32'hDEADBEEF), 4, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            @(negedge clk);
            req_window_id = 12'hABC;
            req_valid     = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
         if (!rsp_valid || !rsp_hit || rsp_addr != 6'd2 ||
             rsp_payload != PAYLOAD_W'(32'hDEADBEEF) || req_ready || !busy) bad++;
      end
      check_eq("stall_stable", W'(bad), W'(0));
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("stall_rel_valid", W'(rsp_valid), W'(0));
      check_eq("stall_rel_ready", W'(req_ready), W'(1));
      check_eq("stall_rel_busy",  W'(busy),      W'(0));
      lookup(12'hABC, lat);
      expect_rsp("after_stall", 1'b1, 5, PAYLOAD_W'(32'h12345678), 7, lat);
      consume("after_stall");

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      req_window_id = 12'h7FF;
      req_valid     = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cnt = 0;
      while (ram_read_addr != 6'd20 && cnt < 100) begin
         @(posedge clk);
         #1 cnt++;
      end
      check_eq("mid_addr20", W'(ram_read_addr), W'(20));
      check_eq("mid_busy",   W'(busy),          W'(1));
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_raddr",     W'(ram_read_addr), W'(0));
      check_eq("arst_busy",      W'(busy),          W'(0));
      check_eq("arst_req_ready", W'(req_ready),     W'(1));
      check_eq("arst_rsp_valid", W'(rsp_valid),     W'(0));
      check_eq("arst_rsp_hit",   W'(rsp_hit),       W'(0));
      rst_n = 1'b1;
      lookup(12'h042, lat);
      expect_rsp("post_rst", 1'b1, 2, PAYLOAD_W'(32'hDEADBEEF), 4, lat);
      consume("post_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
